temp_window_feeder: RTL and testbench
=====================================

Name: temp_window_feeder

Overview:
Upstream sequencer for the ANN temperature predictor. It accepts a stream of daily max-temperature samples and keeps a sliding window of WIN+1 samples. For each window it presents 4 inputs plus a target to the ANN and pulses calculation start. It then waits for the ANN ready edge, captures the prediction, optionally pulses a training step, and slides the window by one sample.

Parameters:
DATA_W, 156, width of one temperature/prediction word (INPUT_SIZE*12).
WIN, 4, number of ANN temperature inputs; buffer depth is WIN+1.
CALC_CYCLES, 5, number of cycles Calc_start_h is held high.
TIMEOUT, 255, maximum cycles spent waiting for the ANN ready edge.
CNT_W, 16, width of Window_count.

Ports:
Clk  in  1  system clock; all logic on its rising edge.
Reset_h  in  1  synchronous, active-high reset.
Sample_in  in  DATA_W  next daily temperature sample.
Sample_valid_h  in  1  Sample_in is valid.
Sample_ready_h  out  1  block accepts a sample this cycle.
Temperature_out_0..3  out  DATA_W each  window to ANN; _0 is the oldest sample.
Target_out  out  DATA_W  newest buffered sample; drives the ANN Target input.
Calc_start_h  out  1  drives the ANN tb_rev_ready_h.
Ann_ready_h  in  1  ANN Ready_Signal (level).
Pred_in  in  DATA_W  ANN Data_out.
Pred_out  out  DATA_W  captured prediction.
Pred_valid_h  out  1  one-cycle pulse when Pred_out is updated.
Train_en_h  in  1  request a training pulse after each prediction.
Train_start_h  out  1  drives the ANN training_enable_h.
Window_count  out  CNT_W  number of completed windows.
Err_h  out  1  sticky timeout flag.

Behaviour:
- Reset (Reset_h=1 at a Clk edge): state=FILL, fill count=0, buffer cleared, and all outputs 0 except Sample_ready_h, which is 1 from the first cycle after reset. Reset overrides every state, including mid-calculation.
- Sample acceptance: a sample is accepted when Sample_valid_h && Sample_ready_h.
  - Shift on accept: buf[i]<=buf[i+1] for i<WIN; buf[WIN]<=Sample_in.
  - Temperature_out_k=buf[k]; Target_out=buf[WIN].
- Sample_ready_h is 1 only in FILL and SLIDE. Sample_valid_h in any other state is ignored and nothing is shifted.
- FILL: accept samples. On the accept that completes WIN+1 samples, go to CALC next cycle.
- CALC: Calc_start_h=1 for exactly CALC_CYCLES cycles, then WAIT_CALC.
- Ready edge detect: a rising edge of Ann_ready_h (registered previous value 0, current value 1) is armed from CALC entry.
  - An edge seen during CALC is latched and consumed on the first WAIT_CALC cycle.
  - A level that is already high at CALC entry is not an edge.
- WAIT_CALC, on the edge:
  - Pred_out<=Pred_in (see Optional Feature) and Pred_valid_h=1 for 1 cycle.
  - Window_count++, saturating at all-ones.
  - Train_en_h is sampled in that same cycle: 1 -> TRAIN, 0 -> SLIDE.
- WAIT_CALC timeout: if TIMEOUT cycles elapse in WAIT_CALC with no edge:
  - Err_h<=1, sticky until reset.
  - Window_count++; no Pred_valid_h pulse; Pred_out keeps its old value.
  - Go to SLIDE; training is skipped.
- TRAIN: Train_start_h=1 for 1 cycle, then SLIDE.
- SLIDE: accept exactly one sample (shift), then go to CALC next cycle. Wait indefinitely if no sample arrives.
- Latency:
  - Last window sample accepted at edge N -> Calc_start_h high from edge N+1.
  - Ready edge sampled at edge M -> Pred_valid_h high in cycle M+1.
- Window outputs stay stable from CALC entry until the next accept.

Optional Feature:
Macro TEMP_WINDOW_FEEDER_SCALE_EN.
- Defined: Pred_out = zero-extended (Pred_in[25:0] / 1000). This is an unsigned integer divide using an iterative or constant-reciprocal divider that must finish before the Pred_valid_h pulse. Any extra cycles are spent in WAIT_CALC after the edge, with Pred_valid_h delayed by the same amount.
- Undefined: Pred_out = Pred_in, unmodified.

Test Plan:
1. Reset, then feed samples 1,2,3,4,5 one per cycle -> Sample_ready_h drops the cycle after the 5th accept; Calc_start_h high for 5 cycles; Temperature_out_0..3=1,2,3,4; Target_out=5.
2. After CALC, raise Ann_ready_h with Pred_in=0x2A and Train_en_h=1 -> Pred_out=0x2A and Pred_valid_h one cycle; Train_start_h one cycle; Window_count=1; Sample_ready_h=1.
3. Continue with sample 6 -> outputs 2,3,4,5 and Target_out=6, Calc_start_h re-asserts; with Train_en_h=0 the second prediction produces no Train_start_h, and Window_count=2.
4. Hold Ann_ready_h=0 through WAIT_CALC -> after 255 cycles Err_h=1, no Pred_valid_h, SLIDE entered; Err_h stays 1 through later windows.
5. Assert Reset_h mid WAIT_CALC -> next cycle all outputs 0 and Sample_ready_h=1; 5 new samples are needed before Calc_start_h.
6. Pred_in low bits=0x186A0 -> Pred_out=0x64 with TEMP_WINDOW_FEEDER_SCALE_EN, 0x186A0 without.

Source files
------------

// File: rtl/temp_window_feeder.sv
// temp_window_feeder: sliding-window sequencer in front of the ANN temperature
// predictor. Buffers WIN+1 daily samples, starts a calculation per window,
// captures the prediction on the ANN ready edge, optionally pulses training,
// then slides the window by one sample.
// Optional build macro: TEMP_WINDOW_FEEDER_SCALE_EN (prediction scaled by 1/1000
// through an iterative divider that runs inside WAIT_CALC after the ready edge).
module temp_window_feeder #(
  parameter int unsigned DATA_W      = 156,
  parameter int unsigned WIN         = 4,
  parameter int unsigned CALC_CYCLES = 5,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic [DATA_W-1:0] Sample_in,
  input  logic              Sample_valid_h,
  output logic              Sample_ready_h,
  output logic [DATA_W-1:0] Temperature_out_0,
  output logic [DATA_W-1:0] Temperature_out_1,
  output logic [DATA_W-1:0] Temperature_out_2,
  output logic [DATA_W-1:0] Temperature_out_3,
  output logic [DATA_W-1:0] Target_out,
  output logic              Calc_start_h,
  input  logic              Ann_ready_h,
  input  logic [DATA_W-1:0] Pred_in,
  output logic [DATA_W-1:0] Pred_out,
  output logic              Pred_valid_h,
  input  logic              Train_en_h,
  output logic              Train_start_h,
  output logic [CNT_W-1:0]  Window_count,
  output logic              Err_h
);

  localparam int unsigned DEPTH  = WIN + 1;
  localparam int unsigned FILL_W = $clog2(WIN + 1);
  localparam int unsigned CALC_W = $clog2(CALC_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_FILL,
    ST_CALC,
    ST_WAIT_CALC,
    ST_TRAIN,
    ST_SLIDE
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [FILL_W-1:0]   fill_cnt_q;
  logic [CALC_W-1:0]   calc_cnt_q;
  logic [TO_W-1:0]     wait_cnt_q;
  logic                ready_d_q;
  logic                edge_lat_q;
  logic [DATA_W-1:0]   win_q [DEPTH];

  logic                ready_edge_c;
  logic                accept_c;
  logic                hit_c;
  logic                timeout_c;
  logic                finish_c;
  logic [DATA_W-1:0]   pred_result_c;

`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
  localparam int unsigned DIV_W     = 26;
  localparam int unsigned DIV_CNT_W = 5;
  localparam int unsigned REM_W     = 10;
  localparam int unsigned REM_SH_W  = REM_W + 1;
  localparam int unsigned DIVISOR   = 1000;

  logic                 div_busy_q;
  logic [DIV_CNT_W-1:0] div_cnt_q;
  logic [REM_W-1:0]     div_rem_q;
  logic [DIV_W-1:0]     div_quo_q;
  logic                 train_req_q;

  logic [REM_SH_W-1:0]  rem_shift_c;
  logic                 rem_ge_c;
  logic [REM_W-1:0]     rem_next_c;
  logic [DIV_W-1:0]     quo_next_c;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift_c = {div_rem_q, div_quo_q[DIV_W-1]};
    rem_ge_c    = (rem_shift_c >= REM_SH_W'(DIVISOR));
    rem_next_c  = rem_ge_c ? REM_W'(rem_shift_c - REM_SH_W'(DIVISOR)) : REM_W'(rem_shift_c);
    quo_next_c  = {div_quo_q[DIV_W-2:0], rem_ge_c};
  end

  assign pred_result_c = DATA_W'(quo_next_c);
`else
  assign pred_result_c = Pred_in;
`endif

  // Rising edge of the ANN ready level against its registered previous value
  assign ready_edge_c = Ann_ready_h & ~ready_d_q;

  assign Temperature_out_0 = win_q[0];
  assign Temperature_out_1 = win_q[1];
  assign Temperature_out_2 = win_q[2];
  assign Temperature_out_3 = win_q[3];
  assign Target_out        = win_q[WIN];

  // State register
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    hit_c     = 1'b0;
    timeout_c = 1'b0;
    finish_c  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (Sample_valid_h) begin
          accept_c = 1'b1;
          if (fill_cnt_q == FILL_W'(WIN)) begin
            state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (calc_cnt_q == CALC_W'(CALC_CYCLES - 1)) begin
          state_nxt = ST_WAIT_CALC;
        end
      end
      ST_WAIT_CALC: begin
`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
        if (div_busy_q) begin
          if (div_cnt_q == DIV_CNT_W'(DIV_W - 1)) begin
            finish_c  = 1'b1;
            state_nxt = train_req_q ? ST_TRAIN : ST_SLIDE;
          end
        end else if (ready_edge_c || edge_lat_q) begin
          hit_c = 1'b1;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_nxt = ST_SLIDE;
        end
`else
        if (ready_edge_c || edge_lat_q) begin
          hit_c     = 1'b1;
          finish_c  = 1'b1;
          state_nxt = Train_en_h ? ST_TRAIN : ST_SLIDE;
        end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_nxt = ST_SLIDE;
        end
`endif
      end
      ST_TRAIN: begin
        state_nxt = ST_SLIDE;
      end
      ST_SLIDE: begin
        if (Sample_valid_h) begin
          accept_c  = 1'b1;
          state_nxt = ST_CALC;
        end
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // Fill/calc/wait counters, ready history and the edge latch armed during CALC
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      fill_cnt_q <= '0;
      calc_cnt_q <= '0;
      wait_cnt_q <= '0;
      ready_d_q  <= 1'b0;
      edge_lat_q <= 1'b0;
    end else begin
      ready_d_q <= Ann_ready_h;
      if (accept_c && (state_q == ST_FILL) && (fill_cnt_q != FILL_W'(WIN))) begin
        fill_cnt_q <= fill_cnt_q + FILL_W'(1);
      end
      if (state_q == ST_CALC) begin
        calc_cnt_q <= calc_cnt_q + CALC_W'(1);
      end else begin
        calc_cnt_q <= '0;
      end
      if (state_q == ST_WAIT_CALC) begin
        wait_cnt_q <= wait_cnt_q + TO_W'(1);
      end else begin
        wait_cnt_q <= '0;
      end
      edge_lat_q <= (state_q == ST_CALC) && (ready_edge_c || edge_lat_q);
    end
  end

  // Sample window: shift towards index 0 on every accept
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        win_q[i] <= '0;
      end
    end else if (accept_c) begin
      for (int i = 0; i < int'(WIN); i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[WIN] <= Sample_in;
    end
  end

`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
  // Iterative divide by 1000, started on the ready edge
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      div_busy_q  <= 1'b0;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= '0;
      train_req_q <= 1'b0;
    end else if (hit_c) begin
      div_busy_q  <= 1'b1;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quo_q   <= Pred_in[DIV_W-1:0];
      train_req_q <= Train_en_h;
    end else if (div_busy_q) begin
      div_cnt_q  <= div_cnt_q + DIV_CNT_W'(1);
      div_rem_q  <= rem_next_c;
      div_quo_q  <= quo_next_c;
      div_busy_q <= ~finish_c;
    end
  end
`endif

  // Registered outputs, derived from the next state and the strobes
  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      Sample_ready_h <= 1'b1;
      Calc_start_h   <= 1'b0;
      Train_start_h  <= 1'b0;
      Pred_valid_h   <= 1'b0;
      Pred_out       <= '0;
      Window_count   <= '0;
      Err_h          <= 1'b0;
    end else begin
      Sample_ready_h <= (state_nxt == ST_FILL) || (state_nxt == ST_SLIDE);
      Calc_start_h   <= (state_nxt == ST_CALC);
      Train_start_h  <= (state_nxt == ST_TRAIN);
      Pred_valid_h   <= finish_c;
      if (finish_c) begin
        Pred_out <= pred_result_c;
      end
      if ((finish_c || timeout_c) && (Window_count != '1)) begin
        Window_count <= Window_count + CNT_W'(1);
      end
      if (timeout_c) begin
        Err_h <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_window_feeder.sv
// tb_temp_window_feeder: directed sequence with randomized data, checked against
// a queue-based model of the sample window, prediction and counters.
`timescale 1ns/1ps
module tb_temp_window_feeder;

  localparam int unsigned DATA_W      = 156;
  localparam int unsigned WIN         = 4;
  localparam int unsigned CALC_CYCLES = 5;
  localparam int unsigned TIMEOUT     = 255;
  localparam int unsigned CNT_W       = 16;
`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
  localparam int EXTRA = 26;
`else
  localparam int EXTRA = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_h = 1'b1;
  logic [DATA_W-1:0] Sample_in = '0;
  logic              Sample_valid_h = 1'b0;
  logic              Sample_ready_h;
  logic [DATA_W-1:0] Temperature_out_0, Temperature_out_1, Temperature_out_2, Temperature_out_3;
  logic [DATA_W-1:0] Target_out;
  logic              Calc_start_h;
  logic              Ann_ready_h = 1'b0;
  logic [DATA_W-1:0] Pred_in = '0;
  logic [DATA_W-1:0] Pred_out;
  logic              Pred_valid_h;
  logic              Train_en_h = 1'b0;
  logic              Train_start_h;
  logic [CNT_W-1:0]  Window_count;
  logic              Err_h;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] win_m [$];
  logic [DATA_W-1:0] exp_pred;
  logic [CNT_W-1:0]  exp_count;
  logic              exp_err;

  always #5 Clk = ~Clk;

  temp_window_feeder #(
    .DATA_W(DATA_W), .WIN(WIN), .CALC_CYCLES(CALC_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset_h(Reset_h),
    .Sample_in(Sample_in), .Sample_valid_h(Sample_valid_h), .Sample_ready_h(Sample_ready_h),
    .Temperature_out_0(Temperature_out_0), .Temperature_out_1(Temperature_out_1),
    .Temperature_out_2(Temperature_out_2), .Temperature_out_3(Temperature_out_3),
    .Target_out(Target_out), .Calc_start_h(Calc_start_h),
    .Ann_ready_h(Ann_ready_h), .Pred_in(Pred_in), .Pred_out(Pred_out),
    .Pred_valid_h(Pred_valid_h), .Train_en_h(Train_en_h), .Train_start_h(Train_start_h),
    .Window_count(Window_count), .Err_h(Err_h)
  );

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w = {w[DATA_W-33:0], $urandom};
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] p);
`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
    return DATA_W'(p[25:0] / 26'd1000);
`else
    return p;
`endif
  endfunction

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_window(input string tag);
    chkw({tag, ".t0"}, Temperature_out_0, win_m[0]);
    chkw({tag, ".t1"}, Temperature_out_1, win_m[1]);
    chkw({tag, ".t2"}, Temperature_out_2, win_m[2]);
    chkw({tag, ".t3"}, Temperature_out_3, win_m[3]);
    chkw({tag, ".target"}, Target_out, win_m[WIN]);
  endtask

  task automatic reset_dut();
    Reset_h = 1'b1; Sample_valid_h = 1'b0; Ann_ready_h = 1'b0; Train_en_h = 1'b0;
    tick();
    Reset_h = 1'b0;
    win_m.delete();
    for (int i = 0; i <= int'(WIN); i++) win_m.push_back('0);
    exp_pred = '0; exp_count = '0; exp_err = 1'b0;
    chk1("rst.ready", Sample_ready_h, 1'b1);
    chk1("rst.calc", Calc_start_h, 1'b0);
    chk1("rst.pvalid", Pred_valid_h, 1'b0);
    chk1("rst.train", Train_start_h, 1'b0);
    chk1("rst.err", Err_h, 1'b0);
    chkw("rst.pred", Pred_out, '0);
    chkw("rst.count", DATA_W'(Window_count), '0);
    check_window("rst.win");
  endtask

  // Offer one sample after 'gap' idle cycles; model shifts the window
  task automatic feed(input logic [DATA_W-1:0] v, input int gap);
    for (int i = 0; i < gap; i++) begin
      Sample_valid_h = 1'b0; Sample_in = rnd_word();
      chk1("gap.ready", Sample_ready_h, 1'b1);
      tick();
    end
    Sample_in = v; Sample_valid_h = 1'b1;
    chk1("feed.ready", Sample_ready_h, 1'b1);
    tick();
    Sample_valid_h = 1'b0;
    win_m.push_back(v);
    void'(win_m.pop_front());
    check_window("feed.win");
  endtask

  // CALC phase; junk samples offered must be ignored; optional ready raise at cycle raise_at
  task automatic run_calc(input int raise_at, input logic [DATA_W-1:0] pred, input logic train);
    chk1("calc.ready_low", Sample_ready_h, 1'b0);
    for (int i = 0; i < int'(CALC_CYCLES); i++) begin
      chk1("calc.start", Calc_start_h, 1'b1);
      Sample_valid_h = 1'b1; Sample_in = rnd_word();
      if (i == raise_at) begin
        Ann_ready_h = 1'b1; Pred_in = pred; Train_en_h = train;
      end
      tick();
    end
    Sample_valid_h = 1'b0;
    chk1("calc.end", Calc_start_h, 1'b0);
    chk1("calc.ready", Sample_ready_h, 1'b0);
    check_window("calc.hold");
  endtask

  // From a WAIT_CALC cycle: hold ready low d cycles, then raise it
  task automatic ann_respond(input int d, input logic [DATA_W-1:0] pred, input logic train);
    for (int i = 0; i < d; i++) begin
      Ann_ready_h = 1'b0;
      chk1("wait.pvalid", Pred_valid_h, 1'b0);
      tick();
    end
    Ann_ready_h = 1'b1; Pred_in = pred; Train_en_h = train;
    tick();
    Ann_ready_h = 1'b0; Pred_in = rnd_word(); Train_en_h = ~train;
    for (int i = 0; i < EXTRA; i++) begin
      chk1("div.pvalid", Pred_valid_h, 1'b0);
      tick();
    end
    exp_pred = scale(pred);
    exp_count = exp_count + 1'b1;
    chk1("pred.valid", Pred_valid_h, 1'b1);
    chkw("pred.out", Pred_out, exp_pred);
    chkw("pred.count", DATA_W'(Window_count), DATA_W'(exp_count));
    chk1("pred.train", Train_start_h, train);
    chk1("pred.ready", Sample_ready_h, !train);
    chk1("pred.err", Err_h, exp_err);
    tick();
    chk1("post.pvalid", Pred_valid_h, 1'b0);
    chk1("post.train", Train_start_h, 1'b0);
    chk1("post.ready", Sample_ready_h, 1'b1);
    chkw("post.pred", Pred_out, exp_pred);
  endtask

  // From the first WAIT_CALC cycle: never raise ready
  task automatic run_timeout();
    Ann_ready_h = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      chk1("to.pvalid", Pred_valid_h, 1'b0);
      tick();
    end
    chk1("to.pre_err", Err_h, exp_err);
    chk1("to.pre_ready", Sample_ready_h, 1'b0);
    tick();
    exp_err = 1'b1;
    exp_count = exp_count + 1'b1;
    chk1("to.err", Err_h, 1'b1);
    chk1("to.pvalid_end", Pred_valid_h, 1'b0);
    chk1("to.train", Train_start_h, 1'b0);
    chk1("to.ready", Sample_ready_h, 1'b1);
    chkw("to.pred", Pred_out, exp_pred);
    chkw("to.count", DATA_W'(Window_count), DATA_W'(exp_count));
  endtask

  initial begin
    logic [DATA_W-1:0] p;
    int ra;
    int d;
    logic tr;

    reset_dut();

    // Fill with 1..5
    for (int k = 1; k <= 5; k++) begin
      feed(DATA_W'(k), 0);
      if (k == 4) chk1("fill4.calc", Calc_start_h, 1'b0);
    end
    run_calc(-1, '0, 1'b0);
    ann_respond(0, DATA_W'(32'h2A), 1'b1);

    // Sample 6, no training
    feed(DATA_W'(6), 0);
    run_calc(-1, '0, 1'b0);
    ann_respond(3, rnd_word(), 1'b0);

    // Timeout window, then a later window where Err_h must stay set
    feed(rnd_word(), 1);
    run_calc(-1, '0, 1'b0);
    run_timeout();
    feed(rnd_word(), 2);
    run_calc(-1, '0, 1'b0);
    ann_respond(int'(TIMEOUT) - 1, rnd_word(), 1'b1);

    // Ready edge during CALC is latched and consumed on the first WAIT_CALC cycle
    p = rnd_word();
    feed(rnd_word(), 0);
    run_calc(2, p, 1'b0);
    ann_respond(0, p, 1'b0);

    // Level already high at CALC entry is not an edge
    Ann_ready_h = 1'b1;
    feed(rnd_word(), 0);
    run_calc(-1, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("level.pvalid", Pred_valid_h, 1'b0);
      tick();
    end
    ann_respond(1, rnd_word(), 1'b1);

    // Scaling example value
    feed(rnd_word(), 0);
    run_calc(-1, '0, 1'b0);
    ann_respond(2, DATA_W'(32'h186A0), 1'b0);
`ifdef TEMP_WINDOW_FEEDER_SCALE_EN
    chkw("scale.example", Pred_out, DATA_W'(32'h64));
`else
    chkw("scale.example", Pred_out, DATA_W'(32'h186A0));
`endif

    // Randomized windows
    for (int n = 0; n < 8; n++) begin
      ra = int'($urandom_range(0, 7));
      if (ra > int'(CALC_CYCLES) - 1) ra = -1;
      d = (ra >= 0) ? 0 : int'($urandom_range(0, 30));
      tr = 1'($urandom_range(0, 1));
      p = rnd_word();
      feed(rnd_word(), int'($urandom_range(0, 3)));
      run_calc(ra, p, tr);
      ann_respond(d, p, tr);
    end

    // Reset in the middle of WAIT_CALC
    feed(rnd_word(), 0);
    run_calc(-1, '0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    reset_dut();
    for (int k = 0; k < 4; k++) feed(rnd_word(), 0);
    chk1("refill.calc", Calc_start_h, 1'b0);
    chk1("refill.ready", Sample_ready_h, 1'b1);
    feed(rnd_word(), 0);
    run_calc(-1, '0, 1'b0);
    ann_respond(0, rnd_word(), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
